// File: rtl/ctrl_pipeline_pkg.sv
// Shared RV32I control-path types: opcodes, ALU/compare selects and the control word.
package rv32i_types;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;

    localparam logic [6:0] FUNCT7_BASE  = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT   = 7'b0100000;
    localparam logic [6:0] RV32M_FUNCT7 = 7'b0000001;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_fence = 7'b0001111
    } rv32i_opcode;

    // Low half mirrors funct3 of the base ALU ops; high half mirrors funct3 of RV32M.
    typedef enum logic [3:0] {
        alu_add    = 4'b0000,
        alu_sll    = 4'b0001,
        alu_sra    = 4'b0010,
        alu_sub    = 4'b0011,
        alu_xor    = 4'b0100,
        alu_srl    = 4'b0101,
        alu_or     = 4'b0110,
        alu_and    = 4'b0111,
        alu_mul    = 4'b1000,
        alu_mulh   = 4'b1001,
        alu_mulhsu = 4'b1010,
        alu_mulhu  = 4'b1011,
        alu_div    = 4'b1100,
        alu_divu   = 4'b1101,
        alu_rem    = 4'b1110,
        alu_remu   = 4'b1111
    } alu_ops;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3;

    typedef struct packed {
        logic [6:0]       opcode;
        alu_ops           aluop;
        branch_funct3     cmpop;
        logic [2:0]       funct3;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             load_regfile;
        logic             mem_read;
        logic             mem_write;
        logic             uses_rs1;
        logic             uses_rs2;
        logic             is_m;
    } rv32i_control_word;

    // Base ALU op selected directly by funct3 (add/sll/xor/srl/or/and).
    function automatic alu_ops alu_from_funct3(input logic [2:0] f3);
        return alu_ops'({1'b0, f3});
    endfunction

endpackage

// File: rtl/ctrl_pipeline_decode.sv
// Combinational RV32I(+M) decoder producing a control word and an illegal flag.
module ctrl_decode
    import rv32i_types::*;
#(
    parameter bit M_EXT = 1'b0
) (
    input  logic [INSTR_W-1:0] i_instr,
    output rv32i_control_word  o_ctrl,
    output logic               o_illegal
);

    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    // Field extraction, per-opcode control and legality; illegal words collapse to zero.
    always_comb begin
        o_ctrl        = '0;
        o_illegal     = 1'b0;
        o_ctrl.opcode = i_instr[6:0];
        o_ctrl.funct3 = w_funct3;
        o_ctrl.rd     = i_instr[11:7];
        o_ctrl.rs1    = i_instr[19:15];
        o_ctrl.rs2    = i_instr[24:20];

        case (rv32i_opcode'(i_instr[6:0]))
            op_lui, op_auipc, op_jal: begin
                o_ctrl.load_regfile = 1'b1;
            end
            op_jalr: begin
                o_ctrl.load_regfile = 1'b1;
                o_ctrl.uses_rs1     = 1'b1;
                o_illegal           = (w_funct3 != 3'b000);
            end
            op_br: begin
                o_ctrl.uses_rs1 = 1'b1;
                o_ctrl.uses_rs2 = 1'b1;
                o_ctrl.cmpop    = branch_funct3'(w_funct3);
                o_illegal       = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            end
            op_load: begin
                o_ctrl.load_regfile = 1'b1;
                o_ctrl.mem_read     = 1'b1;
                o_ctrl.uses_rs1     = 1'b1;
                o_illegal           = (w_funct3 == 3'b011) || (w_funct3 > 3'b101);
            end
            op_store: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.uses_rs1  = 1'b1;
                o_ctrl.uses_rs2  = 1'b1;
                o_illegal        = (w_funct3 > 3'b010);
            end
            op_imm: begin
                o_ctrl.load_regfile = 1'b1;
                o_ctrl.uses_rs1     = 1'b1;
                case (w_funct3)
                    3'b010:  o_ctrl.cmpop = blt;
                    3'b011:  o_ctrl.cmpop = bltu;
                    3'b001: begin
                        o_ctrl.aluop = alu_sll;
                        o_illegal    = (w_funct7 != FUNCT7_BASE);
                    end
                    3'b101: begin
                        o_ctrl.aluop = (w_funct7 == FUNCT7_ALT) ? alu_sra : alu_srl;
                        o_illegal    = (w_funct7 != FUNCT7_BASE) && (w_funct7 != FUNCT7_ALT);
                    end
                    default: o_ctrl.aluop = alu_from_funct3(w_funct3);
                endcase
            end
            op_reg: begin
                o_ctrl.load_regfile = 1'b1;
                o_ctrl.uses_rs1     = 1'b1;
                o_ctrl.uses_rs2     = 1'b1;
                if (w_funct7 == FUNCT7_BASE) begin
                    case (w_funct3)
                        3'b010:  o_ctrl.cmpop = blt;
                        3'b011:  o_ctrl.cmpop = bltu;
                        default: o_ctrl.aluop = alu_from_funct3(w_funct3);
                    endcase
                end else if (w_funct7 == FUNCT7_ALT) begin
                    case (w_funct3)
                        3'b000:  o_ctrl.aluop = alu_sub;
                        3'b101:  o_ctrl.aluop = alu_sra;
                        default: o_illegal    = 1'b1;
                    endcase
                end else if ((w_funct7 == RV32M_FUNCT7) && M_EXT) begin
                    o_ctrl.is_m  = 1'b1;
                    o_ctrl.aluop = alu_ops'({1'b1, w_funct3});
                end else begin
                    o_illegal = 1'b1;
                end
            end
            op_fence: begin
            end
            default: o_illegal = 1'b1;
        endcase

        if (o_ctrl.rd == '0) begin
            o_ctrl.load_regfile = 1'b0;
        end
        if (o_illegal) begin
            o_ctrl = '0;
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Decoded control word carried through NUM_STAGES valid-tagged pipeline registers.
module ctrl_pipeline
    import rv32i_types::*;
#(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned BR_STAGE   = 0,
    parameter bit          M_EXT      = 1'b0,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                id_valid_i,
    input  logic [INSTR_W-1:0]                  instr_i,
    input  logic                                stall_i,
    input  logic                                flush_i,
    output rv32i_control_word [NUM_STAGES-1:0]  ctrl_o,
    output logic [NUM_STAGES-1:0]               valid_o,
    output logic                                load_use_stall_o,
    output logic                                illegal_o,
    output logic [CNT_W-1:0]                    bubble_cnt_o
);

    rv32i_control_word                  w_dec;
    logic                               w_dec_illegal;
    logic                               w_rs1_hit;
    logic                               w_rs2_hit;
    logic                               w_accept;
    rv32i_control_word [NUM_STAGES-1:0] w_shift_ctrl;
    logic [NUM_STAGES-1:0]              w_shift_valid;
    rv32i_control_word [NUM_STAGES-1:0] w_nxt_ctrl;
    logic [NUM_STAGES-1:0]              w_nxt_valid;
    logic [CNT_W-1:0]                   w_nxt_cnt;

    rv32i_control_word [NUM_STAGES-1:0] r_ctrl;
    logic [NUM_STAGES-1:0]              r_valid;
    logic [CNT_W-1:0]                   r_bubble_cnt;

    ctrl_decode #(
        .M_EXT (M_EXT)
    ) u_decode (
        .i_instr   (instr_i),
        .o_ctrl    (w_dec),
        .o_illegal (w_dec_illegal)
    );

    assign illegal_o = id_valid_i && w_dec_illegal;

    // Load in stage 0 whose destination is a source of the instruction in ID.
    assign w_rs1_hit = w_dec.uses_rs1 && (w_dec.rs1 == r_ctrl[0].rd);
    assign w_rs2_hit = w_dec.uses_rs2 && (w_dec.rs2 == r_ctrl[0].rd);
    assign load_use_stall_o = id_valid_i && !flush_i && r_valid[0] && r_ctrl[0].mem_read &&
                              (r_ctrl[0].rd != '0) && (w_rs1_hit || w_rs2_hit);

    assign w_accept = id_valid_i && !illegal_o && !load_use_stall_o;

    // One-stage advance with a bubble shifted into stage 0.
    assign w_shift_ctrl  = {r_ctrl[NUM_STAGES-2:0], rv32i_control_word'('0)};
    assign w_shift_valid = {r_valid[NUM_STAGES-2:0], 1'b0};

    // Next-state selection: stall, then flush, then normal advance.
    always_comb begin
        w_nxt_ctrl  = r_ctrl;
        w_nxt_valid = r_valid;
        w_nxt_cnt   = r_bubble_cnt;
        if (stall_i) begin
            if (flush_i) begin
                for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                    if (k < BR_STAGE) begin
                        w_nxt_ctrl[k]  = '0;
                        w_nxt_valid[k] = 1'b0;
                    end
                end
            end
        end else if (flush_i) begin
            w_nxt_ctrl  = w_shift_ctrl;
            w_nxt_valid = w_shift_valid;
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                if (k <= BR_STAGE) begin
                    w_nxt_ctrl[k]  = '0;
                    w_nxt_valid[k] = 1'b0;
                end
            end
        end else begin
            w_nxt_ctrl  = w_shift_ctrl;
            w_nxt_valid = w_shift_valid;
            if (w_accept) begin
                w_nxt_ctrl[0]  = w_dec;
                w_nxt_valid[0] = 1'b1;
            end
            if (load_use_stall_o && (r_bubble_cnt != '1)) begin
                w_nxt_cnt = r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    // Stage and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl       <= '0;
            r_valid      <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_ctrl       <= w_nxt_ctrl;
            r_valid      <= w_nxt_valid;
            r_bubble_cnt <= w_nxt_cnt;
        end
    end

    assign ctrl_o       = r_ctrl;
    assign valid_o      = r_valid;
    assign bubble_cnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: one instance without and one with RV32M.
module tb_ctrl_pipeline;
    import rv32i_types::*;

    localparam int unsigned NS = 3;

    localparam logic [31:0] I_ADDI  = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_ADD   = 32'h0010_8133; // add  x2,x1,x1
    localparam logic [31:0] I_LW5   = 32'h0000_A283; // lw   x5,0(x1)
    localparam logic [31:0] I_ADD6  = 32'h0012_8333; // add  x6,x5,x1
    localparam logic [31:0] I_LW0   = 32'h0000_A003; // lw   x0,0(x1)
    localparam logic [31:0] I_ADDX0 = 32'h0000_0333; // add  x6,x0,x0
    localparam logic [31:0] I_BEQ   = 32'h0020_8063; // beq  x1,x2,0
    localparam logic [31:0] I_MUL   = 32'h0220_8133; // mul  x2,x1,x2
    localparam logic [31:0] I_BAD   = 32'h0000_007F;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] instr;
    logic        stall;
    logic        flush;

    rv32i_control_word [NS-1:0] ctrl_a;
    rv32i_control_word [NS-1:0] ctrl_b;
    logic [NS-1:0] valid_a;
    logic [NS-1:0] valid_b;
    logic          lus_a;
    logic          lus_b;
    logic          ill_a;
    logic          ill_b;
    logic [31:0]   cnt_a;
    logic [31:0]   cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    ctrl_pipeline #(.NUM_STAGES(NS), .BR_STAGE(0), .M_EXT(1'b0), .CNT_W(32)) u_dut_a (
        .clk              (clk),
        .rst              (rst),
        .id_valid_i       (id_valid),
        .instr_i          (instr),
        .stall_i          (stall),
        .flush_i          (flush),
        .ctrl_o           (ctrl_a),
        .valid_o          (valid_a),
        .load_use_stall_o (lus_a),
        .illegal_o        (ill_a),
        .bubble_cnt_o     (cnt_a)
    );

    ctrl_pipeline #(.NUM_STAGES(NS), .BR_STAGE(0), .M_EXT(1'b1), .CNT_W(32)) u_dut_b (
        .clk              (clk),
        .rst              (rst),
        .id_valid_i       (id_valid),
        .instr_i          (instr),
        .stall_i          (stall),
        .flush_i          (flush),
        .ctrl_o           (ctrl_b),
        .valid_o          (valid_b),
        .load_use_stall_o (lus_b),
        .illegal_o        (ill_b),
        .bubble_cnt_o     (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic st, input logic fl);
        id_valid = v;
        instr    = ins;
        stall    = st;
        flush    = fl;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, I_ADDI, 1'b0, 1'b0);
        step();
        step();
        check("rst_valid", 64'(valid_a), 64'(0));
        check("rst_ctrl_zero", 64'(ctrl_a == '0), 64'(1));
        check("rst_cnt", 64'(cnt_a), 64'(0));
        rst = 1'b0;

        // Back-to-back independent stream
        drive(1'b1, I_ADDI, 1'b0, 1'b0);
        check("stream_lus_addi", 64'(lus_a), 64'(0));
        check("stream_ill_addi", 64'(ill_a), 64'(0));
        step();
        check("addi_s0_valid", 64'(valid_a[0]), 64'(1));
        check("addi_s0_rd", 64'(ctrl_a[0].rd), 64'(1));
        check("addi_s0_wr", 64'(ctrl_a[0].load_regfile), 64'(1));
        check("addi_s0_opc", 64'(ctrl_a[0].opcode), 64'(7'h13));
        check("addi_s0_rs2", 64'(ctrl_a[0].uses_rs2), 64'(0));
        drive(1'b1, I_ADD, 1'b0, 1'b0);
        check("stream_lus_add", 64'(lus_a), 64'(0));
        step();
        check("addi_s1_valid", 64'(valid_a[1]), 64'(1));
        check("addi_s1_rd", 64'(ctrl_a[1].rd), 64'(1));
        check("add_s0_rd", 64'(ctrl_a[0].rd), 64'(2));
        check("add_s0_rs2", 64'(ctrl_a[0].uses_rs2), 64'(1));
        drive(1'b0, I_ADD, 1'b0, 1'b0);
        step();
        check("addi_s2_valid", 64'(valid_a[2]), 64'(1));
        check("addi_s2_rd", 64'(ctrl_a[2].rd), 64'(1));
        check("add_s1_rd", 64'(ctrl_a[1].rd), 64'(2));
        check("idle_s0_valid", 64'(valid_a[0]), 64'(0));
        check("idle_s0_zero", 64'(ctrl_a[0] == '0), 64'(1));

        // Load-use, first under a global stall, then released
        drive(1'b1, I_LW5, 1'b0, 1'b0);
        check("lw_lus", 64'(lus_a), 64'(0));
        step();
        check("lw_s0_mr", 64'(ctrl_a[0].mem_read), 64'(1));
        check("lw_s0_rd", 64'(ctrl_a[0].rd), 64'(5));
        drive(1'b1, I_ADD6, 1'b1, 1'b0);
        check("lu_stall_lus", 64'(lus_a), 64'(1));
        step();
        check("lu_stall_hold_rd", 64'(ctrl_a[0].rd), 64'(5));
        check("lu_stall_hold_v", 64'(valid_a[0]), 64'(1));
        check("lu_stall_cnt", 64'(cnt_a), 64'(0));
        drive(1'b1, I_ADD6, 1'b0, 1'b0);
        check("lu_lus", 64'(lus_a), 64'(1));
        step();
        check("lu_bubble_v", 64'(valid_a[0]), 64'(0));
        check("lu_lw_s1_rd", 64'(ctrl_a[1].rd), 64'(5));
        check("lu_cnt", 64'(cnt_a), 64'(1));
        check("lu_lus_clear", 64'(lus_a), 64'(0));
        step();
        check("lu_dep_s0_v", 64'(valid_a[0]), 64'(1));
        check("lu_dep_s0_rd", 64'(ctrl_a[0].rd), 64'(6));
        check("lu_cnt_hold", 64'(cnt_a), 64'(1));

        // Flush masks a load-use hazard and does not count
        drive(1'b1, I_LW5, 1'b0, 1'b0);
        step();
        drive(1'b1, I_ADD6, 1'b0, 1'b1);
        check("flush_mask_lus", 64'(lus_a), 64'(0));
        step();
        check("flush_lu_s0_v", 64'(valid_a[0]), 64'(0));
        check("flush_lu_s1_rd", 64'(ctrl_a[1].rd), 64'(5));
        check("flush_lu_cnt", 64'(cnt_a), 64'(1));

        // Load into x0 never creates a hazard nor writes
        drive(1'b1, I_LW0, 1'b0, 1'b0);
        step();
        check("lw0_mr", 64'(ctrl_a[0].mem_read), 64'(1));
        check("lw0_wr", 64'(ctrl_a[0].load_regfile), 64'(0));
        drive(1'b1, I_ADDX0, 1'b0, 1'b0);
        check("lw0_lus", 64'(lus_a), 64'(0));
        step();
        check("lw0_dep_v", 64'(valid_a[0]), 64'(1));
        check("lw0_dep_rd", 64'(ctrl_a[0].rd), 64'(6));

        // Branch flush at stage 0
        drive(1'b1, I_BEQ, 1'b0, 1'b0);
        step();
        check("beq_s0_v", 64'(valid_a[0]), 64'(1));
        check("beq_s0_opc", 64'(ctrl_a[0].opcode), 64'(7'h63));
        drive(1'b1, I_ADDI, 1'b0, 1'b1);
        step();
        check("flush_s0_v", 64'(valid_a[0]), 64'(0));
        check("flush_s1_v", 64'(valid_a[1]), 64'(1));
        check("flush_s1_opc", 64'(ctrl_a[1].opcode), 64'(7'h63));

        // Flush under stall: everything holds, ID discarded
        drive(1'b1, I_BEQ, 1'b0, 1'b0);
        step();
        drive(1'b1, I_ADDI, 1'b1, 1'b1);
        step();
        check("sflush_s0_v", 64'(valid_a[0]), 64'(1));
        check("sflush_s0_opc", 64'(ctrl_a[0].opcode), 64'(7'h63));
        check("sflush_s1_v", 64'(valid_a[1]), 64'(0));
        check("sflush_s2_opc", 64'(ctrl_a[2].opcode), 64'(7'h63));

        // M-extension decode and illegal opcodes
        drive(1'b1, I_MUL, 1'b0, 1'b0);
        check("mul_ill_nom", 64'(ill_a), 64'(1));
        check("mul_ill_m", 64'(ill_b), 64'(0));
        step();
        check("mul_s0_v_nom", 64'(valid_a[0]), 64'(0));
        check("mul_s0_v_m", 64'(valid_b[0]), 64'(1));
        check("mul_s0_ism", 64'(ctrl_b[0].is_m), 64'(1));
        check("mul_s0_aluop", 64'(ctrl_b[0].aluop), 64'(4'b1000));
        drive(1'b1, I_BAD, 1'b0, 1'b0);
        check("bad_ill_nom", 64'(ill_a), 64'(1));
        check("bad_ill_m", 64'(ill_b), 64'(1));
        step();
        check("bad_s0_v_nom", 64'(valid_a[0]), 64'(0));
        check("bad_s0_v_m", 64'(valid_b[0]), 64'(0));
        check("bad_mul_s1_v", 64'(valid_b[1]), 64'(1));

        // Reset wins over simultaneous stall and flush
        drive(1'b1, I_ADDI, 1'b1, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_valid_b", 64'(valid_b), 64'(0));
        check("rst2_ctrl_b", 64'(ctrl_b == '0), 64'(1));
        check("rst2_cnt_a", 64'(cnt_a), 64'(0));
        check("rst2_cnt_b", 64'(cnt_b), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ctrl_pipeline.md
# ctrl_pipeline

Parametrised control path for the pipelined RV32I core. It decodes the instruction in ID into an `rv32i_control_word` and carries that word through NUM_STAGES pipeline registers (ID/EX onward), each with a valid bit. It inserts bubbles on load-use hazards, flushes and illegal opcodes, and honours a global stall. It replaces the single-cycle combinational control ROM; decoding moves into a sub-module.

## Interface
- NUM_STAGES, 3: control registers after ID (index 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB); legal range 2..6.
- BR_STAGE, 0: stage index whose control word resolves branches; must be < NUM_STAGES-1.
- M_EXT, 0: 1 = decode RV32M (op_reg, funct7 = 7'b0000001); 0 = treat those encodings as illegal.
- CNT_W, 32: width of the hazard-bubble counter.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid_i  in  1  ID holds a real instruction.
- instr_i  in  32  raw instruction in ID.
- stall_i  in  1  global back-pressure (memory wait); freezes the pipeline.
- flush_i  in  1  branch/jump redirect resolved in stage BR_STAGE.
- ctrl_o  out  NUM_STAGES x rv32i_control_word  registered control word per stage.
- valid_o  out  NUM_STAGES  registered valid per stage.
- load_use_stall_o  out  1  combinational; fetch/ID must hold this cycle.
- illegal_o  out  1  combinational; id_valid_i with an undecodable instruction.
- bubble_cnt_o  out  CNT_W  count of load-use bubbles inserted.

## Operation
- Decode: opcode, funct3, funct7, rd, rs1 and rs2 go into the control word (aluop, cmpop, load_regfile, mem_read, mem_write, uses_rs1, uses_rs2, is_m, rd/rs1/rs2, funct3).
- For U/J-type, uses_rs1 = uses_rs2 = 0.
- rd = 0 forces load_regfile = 0.
- Bubble: all-zero control word with valid = 0.
- load_use_stall_o = id_valid_i & valid_o[0] & ctrl_o[0].mem_read & (ctrl_o[0].rd != 0) & ((uses_rs1 & rs1 == ctrl_o[0].rd) | (uses_rs2 & rs2 == ctrl_o[0].rd)). It is masked to 0 while flush_i = 1.
- Per-cycle update, first match wins:
  1. rst: every valid_o = 0, every ctrl_o = 0, bubble_cnt_o = 0.
  2. stall_i: all stages hold. If flush_i is also set, stages 0..BR_STAGE-1 become bubbles and the rest hold. Decode input is discarded.
  3. flush_i: stages 0..BR_STAGE become bubbles. Stage k > BR_STAGE loads stage k-1.
  4. Normal: stage k >= 1 loads stage k-1. Stage 0 loads the decoded word if id_valid_i & !illegal_o & !load_use_stall_o, otherwise a bubble.
- bubble_cnt_o increments by 1 on each normal-advance cycle with load_use_stall_o = 1. It saturates at all-ones.
- Illegal instructions never enter stage 0. Exception handling sits outside this block.

## Timing
- Decode-to-stage-0 latency is 1 cycle; each further stage adds 1 cycle.
- The instruction in ID at edge t appears on ctrl_o[k] after edge t+k+1, absent stalls.
- load_use_stall_o and illegal_o are combinational from instr_i and stage 0 in the same cycle. There is no registered output path for them.
- A load-use hazard costs exactly one bubble. The dependent instruction enters stage 0 on the following non-stalled edge.
- Simultaneous stall_i and load-use: the stall dominates and nothing advances. load_use_stall_o stays asserted so ID keeps holding.
- Reset during stall or flush clears everything on the same edge.

## Structure
- Package rv32i_types gains:
  - control-word fields rd, rs1, rs2, funct3, uses_rs1, uses_rs2, is_m;
  - alu_ops entries for M-extension operations;
  - the constant RV32M_FUNCT7 = 7'b0000001.
- Sub-module ctrl_decode is purely combinational. It takes instr_i and M_EXT and produces the control word and illegal.
- ctrl_pipeline instantiates ctrl_decode and holds the stage registers, the hazard compare and the counter.

## Test plan
- Reset: assert rst for 2 cycles with id_valid_i = 1 -> all valid_o = 0, ctrl_o = 0, bubble_cnt_o = 0.
- Stream: addi x1,x0,5 then add x2,x1,x1, no stalls -> addi on ctrl_o[0], [1], [2] at cycles 1, 2, 3; load_use_stall_o stays 0.
- Load-use: lw x5,0(x1) then add x6,x5,x1 -> load_use_stall_o = 1 for one cycle, valid_o[0] = 0 the next cycle, add enters stage 0 one cycle later, bubble_cnt_o = 1.
- Load to x0: lw x0,0(x1) then add x6,x0,x0 -> no stall and load_regfile = 0 for the load.
- Flush, BR_STAGE = 0: beq in stage 0 and flush_i = 1 -> next cycle valid_o[0] = 0 and beq on stage 1. Repeat with stall_i = 1: stages hold, ID is discarded, and there is no bubble in stage 0 because BR_STAGE = 0.
- Illegal/M: instr 0x02208133 (mul x2,x1,x2) -> with M_EXT = 0, illegal_o = 1 and a bubble is inserted; with M_EXT = 1, stage 0 gets is_m = 1 and valid = 1. Opcode 7'b1111111 -> illegal_o = 1.
